dab_waveform_meter: RTL and testbench
=====================================

Name: dab_waveform_meter

Overview:
- Measures the DAB bridge voltage patterns V1/V2 (levels -1/0/+1) and recovers the modulation parameters as clock counts: switching period, positive and negative pulse widths of each bridge, and the signed phase shift V1→V2.
- Sits beside the pattern generator and feeds closed-loop checking and telemetry.
- The period reference is a V1 rise event.

Parameters:
- CNT_W, 19, width of all count outputs and internal counters.
- TIMEOUT, 262143, counts without a V1 rise before the signal is declared lost (must be < 2^CNT_W).
- LOCK_N, 4, consecutive consistent periods required to assert locked.
- TOL, 2, maximum |period - previous period| still counted as consistent.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  measurement enable.
- v1  in  2  signed V1 level; 2'b01=+1, 2'b00=0, 2'b11=-1, 2'b10 invalid.
- v2  in  2  signed V2 level, same coding.
- period  out  CNT_W  counts between consecutive V1 rise events.
- pos1, neg1  out  CNT_W  V1 cycles at +1 / -1 within the last period.
- pos2, neg2  out  CNT_W  V2 cycles at +1 / -1 within the same V1 period window.
- phi_cnt  out  CNT_W+1  signed phase, V2 rise relative to V1 rise.
- meas_valid  out  1  one-cycle strobe marking new outputs.
- phase_ok  out  1  exactly one V2 rise in the last period.
- locked  out  1  period stable.
- lost  out  1  timeout or invalid code seen; sticky until the next meas_valid.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. The same applies when en=0, except that the data outputs hold their values.
- Inputs are synchronous to clk with no synchronizer. v1_d and v2_d register the previous samples.
- Rise event:
  - r1 = (v1==+1) && (v1_d!=+1).
  - r2 is defined the same way on v2.
- Level counting: the invalid code 2'b10 counts as level 0 and sets lost.
- States:
  - IDLE: on r1 go to RUN and start the counters. No meas_valid is produced.
  - RUN: on each r1, capture the period, widths and phase. On timeout go to IDLE.
- Counters in RUN:
  - p_cnt <= r1 ? 1 : p_cnt+1.
  - Accumulators a_p1, a_n1, a_p2, a_n2 <= r1 ? (current level match ? 1 : 0) : acc + match.
  - On r1 the captured values are p_cnt and the accumulators before the update, so the cycle of r1 belongs to the new period.
- Phase capture:
  - On r2, d <= (r1 ? 0 : p_cnt) and n2 is incremented, saturating at 2.
  - n2 is cleared on r1; if r2 occurs in the same cycle as r1, n2 becomes 1.
- Phase output on r1:
  - phase_ok = (n2==1).
  - If phase_ok, phi_cnt = (2*d > period) ? d - period : d, giving a range of (-period/2, period/2].
  - If not phase_ok, phi_cnt holds its old value.
- Output timing: outputs and meas_valid update on the clock edge following the cycle in which r1 is seen (latency 1). meas_valid is high for exactly that one cycle.
- Lock:
  - On each capture, a capture with |period - prev_period| <= TOL increments stab_cnt, saturating at LOCK_N; otherwise stab_cnt is cleared.
  - The first capture after IDLE only loads prev_period.
  - locked = (stab_cnt == LOCK_N).
- Timeout: when p_cnt reaches TIMEOUT in RUN:
  - next state is IDLE;
  - lost=1 and locked=0;
  - data outputs are cleared to 0;
  - meas_valid stays 0.
- Saturation: all accumulators saturate at 2^CNT_W-1 with no wrap-around.
- Reset or en low mid-period: the partial period is discarded and no capture occurs.

Test Plan:
- Bench waveform: v1 repeating +1×10, 0×40, -1×10, 0×40; v2 is the same pattern delayed 25 cycles. From the 2nd V1 rise onward: period=100, pos1=neg1=pos2=neg2=10, phi_cnt=+25, phase_ok=1, meas_valid one cycle per period, locked after 1+4 captures.
- Same waveform with v2 delay 75 -> phi_cnt=-25. Delay 50 -> phi_cnt=+50. Delay 0 (simultaneous rises) -> phi_cnt=0.
- Period alternating 100/110 -> locked stays 0. Period changing from 100 to 101 -> locked stays 1.
- Bench TIMEOUT=1000, v1 held at 0 after lock -> at p_cnt=1000 lost=1, locked=0, outputs 0, state IDLE. The next two V1 rises give a valid capture and lost=0.
- v2 with two +1 pulses per period -> phase_ok=0 and phi_cnt unchanged. v1 driving 2'b10 for 5 cycles -> lost=1 and the widths exclude those cycles.
- rst asserted mid-period -> all outputs 0 next cycle, no meas_valid until two V1 rises after release.

Source files
------------

// File: rtl/dab_waveform_meter.sv
// dab_waveform_meter
//   Measures DAB bridge voltage patterns V1/V2 (levels -1/0/+1) and recovers the
//   modulation parameters as clock counts. A V1 rise (transition into +1) marks
//   each period boundary. Every cycle of a V1 rise belongs to the new period.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   en              measurement enable (low: restart, data outputs hold)
//   v1, v2          2-bit signed levels: 01=+1, 00=0, 11=-1, 10=invalid
//   period          counts between consecutive V1 rises
//   pos1/neg1       V1 cycles at +1 / -1 in the last period
//   pos2/neg2       V2 cycles at +1 / -1 in the same V1 window
//   phi_cnt         signed V2-rise offset from the V1 rise, range (-period/2, period/2]
//   meas_valid      one-cycle strobe marking new outputs
//   phase_ok        exactly one V2 rise seen in the last period
//   locked          LOCK_N consecutive periods within TOL of their predecessor
//   lost            timeout or invalid code seen; sticky until the next meas_valid
module dab_waveform_meter #(
  parameter int unsigned CNT_W   = 19,
  parameter int unsigned TIMEOUT = 262143,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned TOL     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              v1,
  input  logic [1:0]              v2,
  output logic [CNT_W-1:0]        period,
  output logic [CNT_W-1:0]        pos1,
  output logic [CNT_W-1:0]        neg1,
  output logic [CNT_W-1:0]        pos2,
  output logic [CNT_W-1:0]        neg2,
  output logic signed [CNT_W:0]   phi_cnt,
  output logic                    meas_valid,
  output logic                    phase_ok,
  output logic                    locked,
  output logic                    lost
);

  localparam logic [1:0]       LvlPos   = 2'b01;
  localparam logic [1:0]       LvlNeg   = 2'b11;
  localparam logic [1:0]       LvlBad   = 2'b10;
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TolC     = CNT_W'(TOL);
  localparam int unsigned      StabW    = (LOCK_N > 0) ? $clog2(LOCK_N + 1) : 1;
  localparam logic [StabW-1:0] StabMax  = StabW'(LOCK_N);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Saturating increment used by every counter.
  function automatic logic [CNT_W-1:0] acc_step(input logic [CNT_W-1:0] acc, input logic hit);
    return (hit && (acc != CntMax)) ? acc + CNT_W'(1) : acc;
  endfunction

  state_e state_q, state_d;

  logic [1:0]       v1_prev_q, v2_prev_q;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
  logic [CNT_W-1:0] ap1_q, ap1_d, an1_q, an1_d, ap2_q, ap2_d, an2_q, an2_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic [1:0]       n2_q, n2_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic             first_q, first_d;

  logic [CNT_W-1:0]      period_q, period_d, pos1_q, pos1_d, neg1_q, neg1_d;
  logic [CNT_W-1:0]      pos2_q, pos2_d, neg2_q, neg2_d;
  logic signed [CNT_W:0] phi_q, phi_d;
  logic                  mv_q, mv_d, pok_q, pok_d, lost_q, lost_d;

  logic                  p1, m1, p2, m2, bad, r1, r2, timeout, consistent;
  logic [CNT_W-1:0]      pdiff;
  logic signed [CNT_W:0] phi_new;

  assign p1  = (v1 == LvlPos);
  assign m1  = (v1 == LvlNeg);
  assign p2  = (v2 == LvlPos);
  assign m2  = (v2 == LvlNeg);
  assign bad = (v1 == LvlBad) || (v2 == LvlBad);
  assign r1  = p1 && (v1_prev_q != LvlPos);
  assign r2  = p2 && (v2_prev_q != LvlPos);

  assign timeout    = (p_cnt_q >= TimeoutC);
  assign pdiff      = (p_cnt_q >= prev_q) ? (p_cnt_q - prev_q) : (prev_q - p_cnt_q);
  assign consistent = (pdiff <= TolC);

  // A V2 rise in the late half of the period is reported as a lag (negative).
  assign phi_new = ({d_q, 1'b0} > {1'b0, p_cnt_q}) ?
                   ($signed({1'b0, d_q}) - $signed({1'b0, p_cnt_q})) : $signed({1'b0, d_q});

  always_comb begin
    state_d  = state_q;
    p_cnt_d  = p_cnt_q;
    ap1_d    = ap1_q;
    an1_d    = an1_q;
    ap2_d    = ap2_q;
    an2_d    = an2_q;
    d_d      = d_q;
    n2_d     = n2_q;
    prev_d   = prev_q;
    stab_d   = stab_q;
    first_d  = first_q;
    period_d = period_q;
    pos1_d   = pos1_q;
    neg1_d   = neg1_q;
    pos2_d   = pos2_q;
    neg2_d   = neg2_q;
    phi_d    = phi_q;
    pok_d    = pok_q;
    lost_d   = lost_q;
    mv_d     = 1'b0;

    if (!en) begin
      state_d = StIdle;
      p_cnt_d = '0;
      ap1_d   = '0;
      an1_d   = '0;
      ap2_d   = '0;
      an2_d   = '0;
      d_d     = '0;
      n2_d    = '0;
      prev_d  = '0;
      stab_d  = '0;
      first_d = 1'b1;
      lost_d  = 1'b0;
    end else begin
      if (r1) begin
        // The rise cycle opens a new period in both states.
        state_d = StRun;
        p_cnt_d = CNT_W'(1);
        ap1_d   = CNT_W'(p1);
        an1_d   = CNT_W'(m1);
        ap2_d   = CNT_W'(p2);
        an2_d   = CNT_W'(m2);
        n2_d    = r2 ? 2'd1 : 2'd0;
        if (r2) d_d = '0;

        if (state_q == StIdle) begin
          first_d = 1'b1;
          stab_d  = '0;
        end else begin
          mv_d     = 1'b1;
          period_d = p_cnt_q;
          pos1_d   = ap1_q;
          neg1_d   = an1_q;
          pos2_d   = ap2_q;
          neg2_d   = an2_q;
          pok_d    = (n2_q == 2'd1);
          if (n2_q == 2'd1) phi_d = phi_new;
          lost_d   = 1'b0;
          prev_d   = p_cnt_q;
          first_d  = 1'b0;
          // The first capture after a restart has no predecessor to compare against.
          if (!first_q) begin
            if (consistent) stab_d = (stab_q == StabMax) ? stab_q : stab_q + StabW'(1);
            else            stab_d = '0;
          end
        end
      end else if (state_q == StRun) begin
        if (timeout) begin
          state_d  = StIdle;
          p_cnt_d  = '0;
          ap1_d    = '0;
          an1_d    = '0;
          ap2_d    = '0;
          an2_d    = '0;
          d_d      = '0;
          n2_d     = '0;
          prev_d   = '0;
          stab_d   = '0;
          first_d  = 1'b1;
          lost_d   = 1'b1;
          period_d = '0;
          pos1_d   = '0;
          neg1_d   = '0;
          pos2_d   = '0;
          neg2_d   = '0;
          phi_d    = '0;
          pok_d    = 1'b0;
        end else begin
          p_cnt_d = acc_step(p_cnt_q, 1'b1);
          ap1_d   = acc_step(ap1_q, p1);
          an1_d   = acc_step(an1_q, m1);
          ap2_d   = acc_step(ap2_q, p2);
          an2_d   = acc_step(an2_q, m2);
          if (r2) begin
            d_d  = p_cnt_q;
            n2_d = (n2_q == 2'd2) ? 2'd2 : n2_q + 2'd1;
          end
        end
      end

      if (bad) lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      v1_prev_q <= 2'b00;
      v2_prev_q <= 2'b00;
      p_cnt_q   <= '0;
      ap1_q     <= '0;
      an1_q     <= '0;
      ap2_q     <= '0;
      an2_q     <= '0;
      d_q       <= '0;
      n2_q      <= '0;
      prev_q    <= '0;
      stab_q    <= '0;
      first_q   <= 1'b1;
      period_q  <= '0;
      pos1_q    <= '0;
      neg1_q    <= '0;
      pos2_q    <= '0;
      neg2_q    <= '0;
      phi_q     <= '0;
      mv_q      <= 1'b0;
      pok_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      v1_prev_q <= v1;
      v2_prev_q <= v2;
      p_cnt_q   <= p_cnt_d;
      ap1_q     <= ap1_d;
      an1_q     <= an1_d;
      ap2_q     <= ap2_d;
      an2_q     <= an2_d;
      d_q       <= d_d;
      n2_q      <= n2_d;
      prev_q    <= prev_d;
      stab_q    <= stab_d;
      first_q   <= first_d;
      period_q  <= period_d;
      pos1_q    <= pos1_d;
      neg1_q    <= neg1_d;
      pos2_q    <= pos2_d;
      neg2_q    <= neg2_d;
      phi_q     <= phi_d;
      mv_q      <= mv_d;
      pok_q     <= pok_d;
      lost_q    <= lost_d;
    end
  end

  assign period     = period_q;
  assign pos1       = pos1_q;
  assign neg1       = neg1_q;
  assign pos2       = pos2_q;
  assign neg2       = neg2_q;
  assign phi_cnt    = phi_q;
  assign meas_valid = mv_q;
  assign phase_ok   = pok_q;
  assign locked     = (stab_q == StabMax);
  assign lost       = lost_q;

endmodule

// File: tb/tb_dab_waveform_meter.sv
module tb_dab_waveform_meter;

  localparam int unsigned CNT_W   = 19;
  localparam int unsigned TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic [1:0] v1 = 2'b00;
  logic [1:0] v2 = 2'b00;

  logic [CNT_W-1:0]      period, pos1, neg1, pos2, neg2;
  logic signed [CNT_W:0] phi_cnt;
  logic                  meas_valid, phase_ok, locked, lost;

  dab_waveform_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .LOCK_N (4),
    .TOL    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .v1        (v1),
    .v2        (v2),
    .period    (period),
    .pos1      (pos1),
    .neg1      (neg1),
    .pos2      (pos2),
    .neg2      (neg2),
    .phi_cnt   (phi_cnt),
    .meas_valid(meas_valid),
    .phase_ok  (phase_ok),
    .locked    (locked),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered while driving; snapshots are taken on each meas_valid.
  int mv_cnt = 0, mv_double = 0, lock_seen = 0, lock_low = 0;
  logic mv_prev = 1'b0;
  logic [CNT_W-1:0]      s_period = '0, s_pos1 = '0, s_neg1 = '0, s_pos2 = '0, s_neg2 = '0;
  logic signed [CNT_W:0] s_phi = '0;
  logic                  s_pok = 1'b0, s_lost = 1'b0;

  // +1 for 10 cycles, -1 for 10 cycles starting at half period, 0 elsewhere.
  function automatic logic [1:0] lvl(input int k, input int per);
    if (k < 10) return 2'b01;
    if (k >= per / 2 && k < per / 2 + 10) return 2'b11;
    return 2'b00;
  endfunction

  task automatic tick(input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    v1 = a;
    v2 = b;
    @(posedge clk);
    #1;
    if (meas_valid) begin
      mv_cnt++;
      if (mv_prev) mv_double++;
      s_period = period; s_pos1 = pos1; s_neg1 = neg1; s_pos2 = pos2; s_neg2 = neg2;
      s_phi = phi_cnt; s_pok = phase_ok; s_lost = lost;
    end
    mv_prev = meas_valid;
    if (locked) lock_seen++;
    else        lock_low++;
  endtask

  // mode 0: normal; 1: two short V2 pulses; 2: V1 invalid for the first 5 negative cycles.
  task automatic run(input int per, input int dly, input int mode, input int ncyc);
    logic [1:0] a, b;
    for (int k = 0; k < ncyc; k++) begin
      a = lvl(k, per);
      b = lvl((k - dly + per) % per, per);
      if (mode == 1) b = ((k >= 25 && k < 30) || (k >= 35 && k < 40)) ? 2'b01 : 2'b00;
      if (mode == 2 && k >= per / 2 && k < per / 2 + 5) a = 2'b10;
      tick(a, b);
    end
  endtask

  task automatic periods(input int n, input int dly);
    for (int i = 0; i < n; i++) run(100, dly, 0, 100);
  endtask

  task automatic clear_stats();
    mv_cnt = 0; mv_double = 0; lock_seen = 0; lock_low = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (period !== '0 || pos1 !== '0 || phi_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_data: period=%0d pos1=%0d phi=%0d, required 0", period, pos1, phi_cnt);
    end
    n_tests++;
    if ({meas_valid, phase_ok, locked, lost} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000", {meas_valid, phase_ok, locked, lost});
    end
  endtask

  task automatic test_basic();
    do_reset();
    clear_stats();
    periods(5, 25);
    n_tests++;
    if (mv_cnt !== 4) begin n_fail++; $display("FAIL basic_mv_cnt: got %0d, required 4", mv_cnt); end
    n_tests++;
    if (s_period !== 100) begin n_fail++; $display("FAIL basic_period: got %0d, required 100", s_period); end
    n_tests++;
    if (s_pos1 !== 10 || s_neg1 !== 10) begin
      n_fail++; $display("FAIL basic_v1_width: got %0d/%0d, required 10/10", s_pos1, s_neg1);
    end
    n_tests++;
    if (s_pos2 !== 10 || s_neg2 !== 10) begin
      n_fail++; $display("FAIL basic_v2_width: got %0d/%0d, required 10/10", s_pos2, s_neg2);
    end
    n_tests++;
    if (s_phi !== 25 || s_pok !== 1'b1) begin
      n_fail++; $display("FAIL basic_phase: got phi=%0d ok=%0d, required 25/1", s_phi, s_pok);
    end
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL basic_lock_early: got %0d, required 0", locked); end
    periods(1, 25);
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_lock: got %0d, required 1", locked); end
    n_tests++;
    if (mv_double !== 0 || mv_cnt !== 5) begin
      n_fail++; $display("FAIL basic_strobe: got doubles=%0d count=%0d, required 0/5", mv_double, mv_cnt);
    end
  endtask

  task automatic test_phase(input int dly, input int exp_phi);
    do_reset();
    clear_stats();
    periods(3, dly);
    n_tests++;
    if (s_phi !== exp_phi || s_pok !== 1'b1 || mv_cnt !== 2) begin
      n_fail++;
      $display("FAIL phase_dly%0d: got phi=%0d ok=%0d mv=%0d, required %0d/1/2",
               dly, s_phi, s_pok, mv_cnt, exp_phi);
    end
  endtask

  task automatic test_lock_alt();
    do_reset();
    clear_stats();
    for (int i = 0; i < 9; i++) run((i % 2 == 1) ? 110 : 100, 25, 0, (i % 2 == 1) ? 110 : 100);
    n_tests++;
    if (lock_seen !== 0) begin n_fail++; $display("FAIL alt_locked: got %0d locked cycles, required 0", lock_seen); end
    n_tests++;
    if (mv_cnt !== 8 || s_period !== 110) begin
      n_fail++; $display("FAIL alt_capture: got mv=%0d period=%0d, required 8/110", mv_cnt, s_period);
    end
  endtask

  task automatic test_lock_drift();
    do_reset();
    periods(6, 25);
    clear_stats();
    for (int i = 0; i < 4; i++) run(101, 25, 0, 101);
    n_tests++;
    if (lock_low !== 0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL drift_locked: got %0d unlocked cycles, required 0", lock_low);
    end
    n_tests++;
    if (s_period !== 101) begin n_fail++; $display("FAIL drift_period: got %0d, required 101", s_period); end
  endtask

  // Continues from test_lock_drift: last V1 rise began a full 101-cycle period.
  task automatic test_timeout();
    int first_lost = -1;
    for (int j = 0; j < 1200; j++) begin
      tick(2'b00, 2'b00);
      if (lost === 1'b1) begin first_lost = j; break; end
    end
    n_tests++;
    if (first_lost !== 899) begin
      n_fail++; $display("FAIL timeout_when: lost at hold cycle %0d, required 899", first_lost);
    end
    n_tests++;
    if (locked !== 1'b0 || meas_valid !== 1'b0 || phase_ok !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags: got locked=%0d mv=%0d ok=%0d, required 0", locked, meas_valid, phase_ok);
    end
    n_tests++;
    if (period !== '0 || pos1 !== '0 || neg2 !== '0 || phi_cnt !== '0) begin
      n_fail++; $display("FAIL timeout_data: got period=%0d pos1=%0d phi=%0d, required 0", period, pos1, phi_cnt);
    end
    clear_stats();
    periods(1, 25);
    n_tests++;
    if (lost !== 1'b1 || mv_cnt !== 0) begin
      n_fail++; $display("FAIL timeout_sticky: got lost=%0d mv=%0d, required 1/0", lost, mv_cnt);
    end
    periods(1, 25);
    n_tests++;
    if (mv_cnt !== 1 || s_period !== 100 || lost !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: got mv=%0d period=%0d lost=%0d, required 1/100/0", mv_cnt, s_period, lost);
    end
  endtask

  task automatic test_double_pulse();
    do_reset();
    periods(3, 25);
    run(100, 25, 1, 100);
    run(100, 25, 1, 100);
    periods(1, 25);
    n_tests++;
    if (s_pok !== 1'b0 || s_phi !== 25) begin
      n_fail++; $display("FAIL double_phase: got ok=%0d phi=%0d, required 0/25", s_pok, s_phi);
    end
    n_tests++;
    if (s_pos2 !== 10 || s_neg2 !== 0) begin
      n_fail++; $display("FAIL double_width: got %0d/%0d, required 10/0", s_pos2, s_neg2);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    periods(3, 25);
    run(100, 25, 2, 100);
    n_tests++;
    if (lost !== 1'b1) begin n_fail++; $display("FAIL invalid_lost: got %0d, required 1", lost); end
    periods(1, 25);
    n_tests++;
    if (s_neg1 !== 5 || s_pos1 !== 10) begin
      n_fail++; $display("FAIL invalid_width: got pos1=%0d neg1=%0d, required 10/5", s_pos1, s_neg1);
    end
    n_tests++;
    if (s_lost !== 1'b0 || lost !== 1'b0) begin
      n_fail++; $display("FAIL invalid_clear: got %0d/%0d, required 0/0", s_lost, lost);
    end
  endtask

  task automatic test_enable_reset_mid();
    do_reset();
    periods(6, 25);
    en = 1'b0;
    tick(2'b00, 2'b00);
    n_tests++;
    if (locked !== 1'b0 || period !== 100 || pos1 !== 10) begin
      n_fail++; $display("FAIL en_low: got locked=%0d period=%0d pos1=%0d, required 0/100/10", locked, period, pos1);
    end
    en = 1'b1;
    run(100, 25, 0, 30);
    rst = 1'b1;
    tick(2'b00, 2'b00);
    rst = 1'b0;
    n_tests++;
    if (period !== '0 || pos1 !== '0 || phi_cnt !== '0 || meas_valid !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got period=%0d pos1=%0d phi=%0d mv=%0d, required 0", period, pos1, phi_cnt, meas_valid);
    end
    clear_stats();
    periods(1, 25);
    n_tests++;
    if (mv_cnt !== 0) begin n_fail++; $display("FAIL rst_first_rise: got %0d strobes, required 0", mv_cnt); end
    periods(1, 25);
    n_tests++;
    if (mv_cnt !== 1 || s_period !== 100) begin
      n_fail++; $display("FAIL rst_second_rise: got mv=%0d period=%0d, required 1/100", mv_cnt, s_period);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase(75, -25);
    test_phase(50, 50);
    test_phase(0, 0);
    test_lock_alt();
    test_lock_drift();
    test_timeout();
    test_double_pulse();
    test_invalid();
    test_enable_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
